bot_upd_handshake: RTL and testbench

- Sits between the rojobot core and the CPU GPIO bot-info/interrupt inputs, in the rojobot clock domain.
- Snapshots the 32-bit bot info word on each rojobot update pulse and raises a level interrupt request.
- Holds the request until the CPU acknowledges; the acknowledge is asynchronous and is synchronized internally.
- Tracks update sequence and overruns so firmware can detect missed updates.

---
 rtl/bot_upd_handshake_if.sv | 25 ++
 rtl/bot_upd_handshake.sv | 126 ++++++++++++
 tb/tb_bot_upd_handshake.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/bot_upd_handshake_if.sv
// Bot-info update handshake bundle between the rojobot core side and the CPU GPIO side.
// The slave modport is the handshake block; the master drives updates and the CPU ack.
interface bot_upd_handshake_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);
  logic              i_upd;
  logic [DATA_W-1:0] i_bot_info;
  logic              i_int_ack;
  logic [DATA_W-1:0] o_bot_info;
  logic              o_upd_req;
  logic [CNT_W-1:0]  o_seq;
  logic [CNT_W-1:0]  o_missed;
  logic              o_busy;

  modport master (
    output i_upd, i_bot_info, i_int_ack,
    input  o_bot_info, o_upd_req, o_seq, o_missed, o_busy
  );

  modport slave (
    input  i_upd, i_bot_info, i_int_ack,
    output o_bot_info, o_upd_req, o_seq, o_missed, o_busy
  );
endinterface

// File: rtl/bot_upd_handshake.sv
// Snapshots rojobot info on each update pulse and holds a level interrupt request
// until the (asynchronous) CPU acknowledge; counts captures and overruns.
module bot_upd_handshake #(
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int OVERWRITE   = 1
) (
  input  logic                clk,
  input  logic                rstn,
  bot_upd_handshake_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PENDING, ACK_HOLD} state_t;

  state_t              state, state_nx;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                ack_s, ack_s_d, ack_rise;
  logic [DATA_W-1:0]   info_q, info_nx;
  logic [CNT_W-1:0]    seq_q, seq_nx;
  logic [CNT_W-1:0]    missed_q, missed_nx;
  logic                req_q, req_nx;
  logic                queued_q, queued_nx;
  logic                do_capture, do_overrun;

  assign ack_s    = ack_sync[SYNC_STAGES-1];
  assign ack_rise = ack_s & ~ack_s_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ack_sync <= '0;
      ack_s_d  <= 1'b0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], bus.i_int_ack};
      ack_s_d  <= ack_s;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      info_q   <= '0;
      seq_q    <= '0;
      missed_q <= '0;
      req_q    <= 1'b0;
      queued_q <= 1'b0;
    end else begin
      state    <= state_nx;
      info_q   <= info_nx;
      seq_q    <= seq_nx;
      missed_q <= missed_nx;
      req_q    <= req_nx;
      queued_q <= queued_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    info_nx    = info_q;
    seq_nx     = seq_q;
    missed_nx  = missed_q;
    req_nx     = req_q;
    queued_nx  = queued_q;
    do_capture = 1'b0;
    do_overrun = 1'b0;

    case (state)
      IDLE: begin
        if (bus.i_upd) begin
          do_capture = 1'b1;
          req_nx     = 1'b1;
          state_nx   = PENDING;
        end
      end
      PENDING: begin
        if (ack_rise) begin
          req_nx   = 1'b0;
          state_nx = ACK_HOLD;
          if (bus.i_upd) begin
            do_capture = 1'b1;
            queued_nx  = 1'b1;
          end
        end else if (bus.i_upd) begin
          do_overrun = 1'b1;
        end
      end
      ACK_HOLD: begin
        if (bus.i_upd) begin
          if (queued_q) begin
            do_overrun = 1'b1;
          end else begin
            do_capture = 1'b1;
            queued_nx  = 1'b1;
          end
        end
        // Leaving on the ack level's fall; an update in this same cycle counts as queued.
        if (!ack_s) begin
          queued_nx = 1'b0;
          if (queued_q || bus.i_upd) begin
            req_nx   = 1'b1;
            state_nx = PENDING;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    if (do_overrun) begin
      missed_nx = (missed_q == '1) ? missed_q : missed_q + 1'b1;
      if (OVERWRITE != 0) do_capture = 1'b1;
    end
    if (do_capture) begin
      info_nx = bus.i_bot_info;
      seq_nx  = seq_q + 1'b1;
    end
  end

  assign bus.o_bot_info = info_q;
  assign bus.o_upd_req  = req_q;
  assign bus.o_seq      = seq_q;
  assign bus.o_missed   = missed_q;
  assign bus.o_busy     = (state != IDLE);

endmodule

// File: tb/tb_bot_upd_handshake.sv
// Drives two instances (overwrite and hold policies) with the same stimulus and
// checks both against hand-derived per-cycle expectations.
module tb_bot_upd_handshake;

  typedef struct {
    logic        upd;
    logic [31:0] info;
    logic        ack;
    logic        req;
    logic [7:0]  seq;
    logic [7:0]  missed;
    logic        busy;
    logic [31:0] data;
    logic [7:0]  seq_h;
    logic [31:0] data_h;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        upd = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] info = '0;
  int          total = 0;
  int          bad = 0;
  int          step = 0;
  vec_t        exp_q[$];
  vec_t        tbl[$];

  always #5 clk = ~clk;

  bot_upd_handshake_if #(.DATA_W(32), .CNT_W(8)) bus_ow ();
  bot_upd_handshake_if #(.DATA_W(32), .CNT_W(8)) bus_hd ();

  assign bus_ow.i_upd      = upd;
  assign bus_ow.i_bot_info = info;
  assign bus_ow.i_int_ack  = ack;
  assign bus_hd.i_upd      = upd;
  assign bus_hd.i_bot_info = info;
  assign bus_hd.i_int_ack  = ack;

  bot_upd_handshake #(.DATA_W(32), .CNT_W(8), .SYNC_STAGES(2), .OVERWRITE(1)) dut_ow (
    .clk(clk), .rstn(rstn), .bus(bus_ow)
  );
  bot_upd_handshake #(.DATA_W(32), .CNT_W(8), .SYNC_STAGES(2), .OVERWRITE(0)) dut_hd (
    .clk(clk), .rstn(rstn), .bus(bus_hd)
  );

  function automatic vec_t mk(input logic u, input logic [31:0] in, input logic a,
                              input logic r, input logic [7:0] s, input logic [7:0] m,
                              input logic b, input logic [31:0] d, input logic [7:0] sh,
                              input logic [31:0] dh);
    vec_t v;
    v.upd = u; v.info = in; v.ack = a; v.req = r; v.seq = s; v.missed = m;
    v.busy = b; v.data = d; v.seq_h = sh; v.data_h = dh;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d: got %h want %h", name, step, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, "_info_ow"}, bus_ow.o_bot_info, 32'h0);
    cmp({tag, "_req_ow"}, {31'h0, bus_ow.o_upd_req}, 32'h0);
    cmp({tag, "_seq_ow"}, {24'h0, bus_ow.o_seq}, 32'h0);
    cmp({tag, "_missed_ow"}, {24'h0, bus_ow.o_missed}, 32'h0);
    cmp({tag, "_busy_ow"}, {31'h0, bus_ow.o_busy}, 32'h0);
    cmp({tag, "_info_hd"}, bus_hd.o_bot_info, 32'h0);
    cmp({tag, "_req_hd"}, {31'h0, bus_hd.o_upd_req}, 32'h0);
    cmp({tag, "_seq_hd"}, {24'h0, bus_hd.o_seq}, 32'h0);
    cmp({tag, "_missed_hd"}, {24'h0, bus_hd.o_missed}, 32'h0);
    cmp({tag, "_busy_hd"}, {31'h0, bus_hd.o_busy}, 32'h0);
  endtask

  task automatic score();
    vec_t e;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty step=%0d: got 0 entries want 1", step);
      return;
    end
    e = exp_q.pop_front();
    cmp("req_ow", {31'h0, bus_ow.o_upd_req}, {31'h0, e.req});
    cmp("seq_ow", {24'h0, bus_ow.o_seq}, {24'h0, e.seq});
    cmp("missed_ow", {24'h0, bus_ow.o_missed}, {24'h0, e.missed});
    cmp("busy_ow", {31'h0, bus_ow.o_busy}, {31'h0, e.busy});
    cmp("info_ow", bus_ow.o_bot_info, e.data);
    cmp("req_hd", {31'h0, bus_hd.o_upd_req}, {31'h0, e.req});
    cmp("seq_hd", {24'h0, bus_hd.o_seq}, {24'h0, e.seq_h});
    cmp("missed_hd", {24'h0, bus_hd.o_missed}, {24'h0, e.missed});
    cmp("busy_hd", {31'h0, bus_hd.o_busy}, {31'h0, e.busy});
    cmp("info_hd", bus_hd.o_bot_info, e.data_h);
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    upd = v.upd; info = v.info; ack = v.ack;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    score();
    step++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; upd = 1'b0; ack = 1'b0; info = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    // upd, info, ack | req, seq, missed, busy, data | seq_h, data_h
    tbl.push_back(mk(0, 32'h0,         0, 0, 0, 0, 0, 32'h0,         0, 32'h0));
    tbl.push_back(mk(1, 32'h1234_5678, 0, 1, 1, 0, 1, 32'h1234_5678, 1, 32'h1234_5678));
    tbl.push_back(mk(0, 32'h0,         1, 1, 1, 0, 1, 32'h1234_5678, 1, 32'h1234_5678));
    tbl.push_back(mk(0, 32'h0,         1, 1, 1, 0, 1, 32'h1234_5678, 1, 32'h1234_5678));
    tbl.push_back(mk(0, 32'h0,         1, 0, 1, 0, 1, 32'h1234_5678, 1, 32'h1234_5678));
    tbl.push_back(mk(0, 32'h0,         0, 0, 1, 0, 1, 32'h1234_5678, 1, 32'h1234_5678));
    tbl.push_back(mk(0, 32'h0,         0, 0, 1, 0, 1, 32'h1234_5678, 1, 32'h1234_5678));
    tbl.push_back(mk(0, 32'h0,         0, 0, 1, 0, 0, 32'h1234_5678, 1, 32'h1234_5678));
    tbl.push_back(mk(1, 32'hAAAA_0001, 0, 1, 2, 0, 1, 32'hAAAA_0001, 2, 32'hAAAA_0001));
    tbl.push_back(mk(1, 32'hAAAA_0002, 0, 1, 3, 1, 1, 32'hAAAA_0002, 2, 32'hAAAA_0001));
    tbl.push_back(mk(0, 32'h0,         1, 1, 3, 1, 1, 32'hAAAA_0002, 2, 32'hAAAA_0001));
    tbl.push_back(mk(0, 32'h0,         1, 1, 3, 1, 1, 32'hAAAA_0002, 2, 32'hAAAA_0001));
    tbl.push_back(mk(0, 32'h0,         1, 0, 3, 1, 1, 32'hAAAA_0002, 2, 32'hAAAA_0001));
    tbl.push_back(mk(0, 32'h0,         0, 0, 3, 1, 1, 32'hAAAA_0002, 2, 32'hAAAA_0001));
    tbl.push_back(mk(0, 32'h0,         0, 0, 3, 1, 1, 32'hAAAA_0002, 2, 32'hAAAA_0001));
    tbl.push_back(mk(0, 32'h0,         0, 0, 3, 1, 0, 32'hAAAA_0002, 2, 32'hAAAA_0001));
    tbl.push_back(mk(1, 32'hBBBB_0001, 0, 1, 4, 1, 1, 32'hBBBB_0001, 3, 32'hBBBB_0001));
    tbl.push_back(mk(0, 32'h0,         1, 1, 4, 1, 1, 32'hBBBB_0001, 3, 32'hBBBB_0001));
    tbl.push_back(mk(0, 32'h0,         1, 1, 4, 1, 1, 32'hBBBB_0001, 3, 32'hBBBB_0001));
    tbl.push_back(mk(1, 32'hCCCC_0001, 1, 0, 5, 1, 1, 32'hCCCC_0001, 4, 32'hCCCC_0001));
    tbl.push_back(mk(0, 32'h0,         1, 0, 5, 1, 1, 32'hCCCC_0001, 4, 32'hCCCC_0001));
    tbl.push_back(mk(0, 32'h0,         0, 0, 5, 1, 1, 32'hCCCC_0001, 4, 32'hCCCC_0001));
    tbl.push_back(mk(0, 32'h0,         0, 0, 5, 1, 1, 32'hCCCC_0001, 4, 32'hCCCC_0001));
    tbl.push_back(mk(0, 32'h0,         0, 1, 5, 1, 1, 32'hCCCC_0001, 4, 32'hCCCC_0001));
    tbl.push_back(mk(0, 32'h0,         1, 1, 5, 1, 1, 32'hCCCC_0001, 4, 32'hCCCC_0001));
    tbl.push_back(mk(0, 32'h0,         1, 1, 5, 1, 1, 32'hCCCC_0001, 4, 32'hCCCC_0001));
    tbl.push_back(mk(0, 32'h0,         1, 0, 5, 1, 1, 32'hCCCC_0001, 4, 32'hCCCC_0001));
    tbl.push_back(mk(1, 32'hDDDD_0001, 0, 0, 6, 1, 1, 32'hDDDD_0001, 5, 32'hDDDD_0001));
    tbl.push_back(mk(1, 32'hEEEE_0001, 0, 0, 7, 2, 1, 32'hEEEE_0001, 5, 32'hDDDD_0001));
    tbl.push_back(mk(0, 32'h0,         0, 1, 7, 2, 1, 32'hEEEE_0001, 5, 32'hDDDD_0001));
    tbl.push_back(mk(0, 32'h0,         1, 1, 7, 2, 1, 32'hEEEE_0001, 5, 32'hDDDD_0001));
    tbl.push_back(mk(0, 32'h0,         1, 1, 7, 2, 1, 32'hEEEE_0001, 5, 32'hDDDD_0001));
    tbl.push_back(mk(0, 32'h0,         1, 0, 7, 2, 1, 32'hEEEE_0001, 5, 32'hDDDD_0001));
    tbl.push_back(mk(0, 32'h0,         0, 0, 7, 2, 1, 32'hEEEE_0001, 5, 32'hDDDD_0001));
    tbl.push_back(mk(0, 32'h0,         0, 0, 7, 2, 1, 32'hEEEE_0001, 5, 32'hDDDD_0001));
    tbl.push_back(mk(0, 32'h0,         0, 0, 7, 2, 0, 32'hEEEE_0001, 5, 32'hDDDD_0001));
    // held ack in IDLE: capture still happens, request waits for a fresh ack edge
    tbl.push_back(mk(0, 32'h0,         1, 0, 7, 2, 0, 32'hEEEE_0001, 5, 32'hDDDD_0001));
    tbl.push_back(mk(0, 32'h0,         1, 0, 7, 2, 0, 32'hEEEE_0001, 5, 32'hDDDD_0001));
    tbl.push_back(mk(0, 32'h0,         1, 0, 7, 2, 0, 32'hEEEE_0001, 5, 32'hDDDD_0001));
    tbl.push_back(mk(1, 32'hF0F0_F0F0, 1, 1, 8, 2, 1, 32'hF0F0_F0F0, 6, 32'hF0F0_F0F0));
    tbl.push_back(mk(0, 32'h0,         1, 1, 8, 2, 1, 32'hF0F0_F0F0, 6, 32'hF0F0_F0F0));
    tbl.push_back(mk(0, 32'h0,         1, 1, 8, 2, 1, 32'hF0F0_F0F0, 6, 32'hF0F0_F0F0));
    tbl.push_back(mk(0, 32'h0,         0, 1, 8, 2, 1, 32'hF0F0_F0F0, 6, 32'hF0F0_F0F0));
    tbl.push_back(mk(0, 32'h0,         0, 1, 8, 2, 1, 32'hF0F0_F0F0, 6, 32'hF0F0_F0F0));
    tbl.push_back(mk(0, 32'h0,         0, 1, 8, 2, 1, 32'hF0F0_F0F0, 6, 32'hF0F0_F0F0));
    tbl.push_back(mk(0, 32'h0,         1, 1, 8, 2, 1, 32'hF0F0_F0F0, 6, 32'hF0F0_F0F0));
    tbl.push_back(mk(0, 32'h0,         1, 1, 8, 2, 1, 32'hF0F0_F0F0, 6, 32'hF0F0_F0F0));
    tbl.push_back(mk(0, 32'h0,         1, 0, 8, 2, 1, 32'hF0F0_F0F0, 6, 32'hF0F0_F0F0));
    tbl.push_back(mk(0, 32'h0,         0, 0, 8, 2, 1, 32'hF0F0_F0F0, 6, 32'hF0F0_F0F0));
    tbl.push_back(mk(0, 32'h0,         0, 0, 8, 2, 1, 32'hF0F0_F0F0, 6, 32'hF0F0_F0F0));
    tbl.push_back(mk(0, 32'h0,         0, 0, 8, 2, 0, 32'hF0F0_F0F0, 6, 32'hF0F0_F0F0));

    do_reset();
    for (int unsigned i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // 300 back-to-back updates with no ack: seq wraps, missed saturates
    do_reset();
    for (int i = 0; i < 300; i++) begin
      apply(mk(1, 32'h1000_0000 + i, 0, 1, 8'((i + 1) % 256),
               (i > 255) ? 8'd255 : 8'(i), 1, 32'h1000_0000 + i, 1, 32'h1000_0000));
    end
    apply(mk(0, 32'h0, 1, 1, 44, 255, 1, 32'h1000_012B, 1, 32'h1000_0000));
    apply(mk(0, 32'h0, 1, 1, 44, 255, 1, 32'h1000_012B, 1, 32'h1000_0000));
    apply(mk(1, 32'h0000_5555, 1, 0, 45, 255, 1, 32'h0000_5555, 2, 32'h0000_5555));

    // asynchronous reset while an update is queued
    @(negedge clk);
    #2;
    rstn = 1'b0; upd = 1'b0; ack = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    rstn = 1'b1;
    apply(mk(0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0));
    apply(mk(1, 32'h0BAD_F00D, 0, 1, 1, 0, 1, 32'h0BAD_F00D, 1, 32'h0BAD_F00D));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
